// File: rtl/filter_pkt_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO for the packet filter output.
// Packets are buffered in full; only complete packets without the drop flag are released.
// Packets flagged by the filter or that overflow the buffer are discarded and counted.
module filter_pkt_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  input  logic [DATA_WIDTH-1:0]     in_tdata,
  input  logic                      in_tlast,
  input  logic                      in_tuser,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic [DATA_WIDTH-1:0]     out_tdata,
  output logic                      out_tlast,
  output logic [CNT_WIDTH-1:0]      pkt_cnt,
  output logic [CNT_WIDTH-1:0]      drop_cnt,
  output logic [CNT_WIDTH-1:0]      ovf_cnt,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W:0]    PtrOne   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]    PtrDepth = DEPTH[ADDR_W:0];
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {StAccept, StDiscard} state_e;

  state_e state;

  // Each RAM word is {tlast, tdata}
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr;   // tentative write pointer
  logic [ADDR_W:0] wr_cmt;   // end of last committed packet
  logic [ADDR_W:0] rd_ptr;

  logic beat;
  logic full;
  logic wr_en;
  logic load;

  // The FIFO never backpressures; overflow is resolved by dropping.
  assign in_tready  = !rst;
  assign beat       = in_tvalid && in_tready;
  assign full       = ((wr_ptr - rd_ptr) == PtrDepth);
  assign wr_en      = beat && (state == StAccept) && !full;
  // Only committed words are read, and only when the output register can take one.
  assign load       = (rd_ptr != wr_cmt) && (!out_tvalid || out_tready);
  assign fill_level = wr_ptr - rd_ptr;

  // Packet storage; no reset needed since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {in_tlast, in_tdata};
    end
  end

  // Write FSM, pointers, statistics and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StAccept;
      wr_ptr     <= '0;
      wr_cmt     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      ovf_cnt    <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
    end else begin
      if (beat) begin
        case (state)
          StAccept: begin
            if (!full) begin
              wr_ptr <= wr_ptr + PtrOne;
              if (in_tlast && !in_tuser) begin
                wr_cmt  <= wr_ptr + PtrOne;
                pkt_cnt <= pkt_cnt + CntOne;
              end else if (in_tlast && in_tuser) begin
                wr_ptr   <= wr_cmt;
                drop_cnt <= drop_cnt + CntOne;
              end
            end else begin
              // Overflow wins over the drop flag, even on a tlast beat.
              wr_ptr  <= wr_cmt;
              ovf_cnt <= ovf_cnt + CntOne;
              if (!in_tlast) begin
                state <= StDiscard;
              end
            end
          end
          StDiscard: begin
            if (in_tlast) begin
              state <= StAccept;
            end
          end
          default: state <= StAccept;
        endcase
      end

      if (load) begin
        rd_ptr     <= rd_ptr + PtrOne;
        out_tvalid <= 1'b1;
        {out_tlast, out_tdata} <= mem[rd_ptr[ADDR_W-1:0]];
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filter_pkt_fifo.sv
// Directed and randomised bench for filter_pkt_fifo with DEPTH = 64, DATA_WIDTH = 16.
module tb_filter_pkt_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [15:0] in_tdata = '0;
  logic        in_tlast = 1'b0;
  logic        in_tuser = 1'b0;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic [15:0] out_tdata;
  logic        out_tlast;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] ovf_cnt;
  logic [6:0]  fill_level;

  int checks = 0;
  int errors = 0;

  logic [16:0] got_q [$];
  logic [16:0] exp_q [$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  bit          rnd_done;

  filter_pkt_fifo #(
    .DATA_WIDTH(16),
    .DEPTH     (64),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tdata  (in_tdata),
    .in_tlast  (in_tlast),
    .in_tuser  (in_tuser),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata (out_tdata),
    .out_tlast (out_tlast),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .ovf_cnt   (ovf_cnt),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  // Output monitor: collects handshaken beats and checks hold-while-stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (out_tvalid !== 1'b1 || out_tdata !== prev_data || out_tlast !== prev_last) begin
            errors++;
            $display("FAIL stability valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                     out_tvalid, out_tdata, out_tlast, prev_data, prev_last);
          end
        end
        prev_stall = out_tvalid && !out_tready;
        prev_data  = out_tdata;
        prev_last  = out_tlast;
        if (out_tvalid && out_tready) got_q.push_back({out_tlast, out_tdata});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last, input logic user);
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = last;
    in_tuser  = user;
    cycle();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b0;
  endtask

  // Back-to-back packet of n beats base, base+1, ...; user applies to the tlast beat.
  task automatic send_pkt(input int n, input logic [15:0] base, input logic user);
    for (int i = 0; i < n; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = base + 16'(i);
      in_tlast  = (i == n - 1);
      in_tuser  = user && (i == n - 1);
      cycle();
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b0;
  endtask

  task automatic add_exp(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 16'(i)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (in_tready !== 1'b0) begin
      errors++; $display("FAIL rst_tready got %b want 0", in_tready);
    end
    cycle();
    checks++;
    if ({out_tvalid, out_tdata, out_tlast, pkt_cnt, drop_cnt, ovf_cnt, fill_level} !== '0) begin
      errors++;
      $display("FAIL rst_outputs valid=%b data=%h last=%b pkt=%0d drop=%0d ovf=%0d fill=%0d want 0",
               out_tvalid, out_tdata, out_tlast, pkt_cnt, drop_cnt, ovf_cnt, fill_level);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_tready !== 1'b1) begin
      errors++; $display("FAIL rst_tready_after got %b want 1", in_tready);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single_pkt();
    out_tready = 1'b1;
    send_pkt(4, 16'h0001, 1'b0);
    add_exp(4, 16'h0001);
    checks++;
    if (out_tvalid !== 1'b0) begin
      errors++; $display("FAIL t1_lat_n1 valid=%b want 0", out_tvalid);
    end
    cycle();
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== 16'h0001) begin
      errors++; $display("FAIL t1_lat_n2 valid=%b data=%h want 1 0001", out_tvalid, out_tdata);
    end
    repeat (6) cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t1_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t1_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++; $display("FAIL t1_pkt_cnt got %0d want 1", pkt_cnt);
    end
  endtask

  task automatic test_drop();
    do_reset();
    out_tready = 1'b1;
    send_pkt(3, 16'h0200, 1'b1);
    send_pkt(2, 16'h0100, 1'b0);
    add_exp(2, 16'h0100);
    repeat (6) cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t2_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t2_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (drop_cnt !== 16'd1 || pkt_cnt !== 16'd1 || ovf_cnt !== 16'd0 || fill_level !== 7'd0) begin
      errors++;
      $display("FAIL t2_counts drop=%0d pkt=%0d ovf=%0d fill=%0d want 1 1 0 0",
               drop_cnt, pkt_cnt, ovf_cnt, fill_level);
    end
  endtask

  task automatic test_back_to_back_ovf();
    do_reset();
    out_tready = 1'b0;
    send_pkt(33, 16'h1000, 1'b0);
    send_pkt(33, 16'h2000, 1'b0);
    add_exp(33, 16'h1000);
    cycle();
    // 33 committed, one already in the output register
    checks++;
    if (ovf_cnt !== 16'd1 || pkt_cnt !== 16'd1 || fill_level !== 7'd32) begin
      errors++;
      $display("FAIL t3_counts ovf=%0d pkt=%0d fill=%0d want 1 1 32", ovf_cnt, pkt_cnt, fill_level);
    end
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== 16'h1000 || out_tlast !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL t3_hold valid=%b data=%h last=%b n=%0d want 1 1000 0 0",
               out_tvalid, out_tdata, out_tlast, got_q.size());
    end
    out_tready = 1'b1;
    repeat (40) cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t3_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t3_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (fill_level !== 7'd0) begin
      errors++; $display("FAIL t3_fill got %0d want 0", fill_level);
    end
  endtask

  task automatic test_long_pkt();
    do_reset();
    out_tready = 1'b1;
    // tuser on the tlast of an overflowed packet must not count as a drop
    send_pkt(70, 16'h3000, 1'b1);
    repeat (4) cycle();
    checks++;
    if (ovf_cnt !== 16'd1 || drop_cnt !== 16'd0 || pkt_cnt !== 16'd0 || fill_level !== 7'd0 ||
        got_q.size() != 0 || in_tready !== 1'b1) begin
      errors++;
      $display("FAIL t4_long ovf=%0d drop=%0d pkt=%0d fill=%0d n=%0d rdy=%b want 1 0 0 0 0 1",
               ovf_cnt, drop_cnt, pkt_cnt, fill_level, got_q.size(), in_tready);
    end
    send_pkt(5, 16'h4000, 1'b0);
    add_exp(5, 16'h4000);
    // exactly DEPTH beats fits
    send_pkt(64, 16'h7000, 1'b0);
    add_exp(64, 16'h7000);
    repeat (72) cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t4_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t4_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (pkt_cnt !== 16'd2 || ovf_cnt !== 16'd1) begin
      errors++; $display("FAIL t4_counts pkt=%0d ovf=%0d want 2 1", pkt_cnt, ovf_cnt);
    end
  endtask

  task automatic test_random();
    int n_good = 0;
    int n_bad  = 0;
    int waited;
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          out_tready = 1'($urandom_range(0, 1));
          cycle();
        end
      end
    join_none
    for (int p = 0; p < 200; p++) begin
      int          len;
      logic        bad;
      logic [15:0] d;
      len = int'($urandom_range(1, 20));
      bad = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < len; i++) begin
        d = 16'($urandom);
        if (!bad) exp_q.push_back({(i == len - 1), d});
        send_beat(d, (i == len - 1), bad && (i == len - 1));
      end
      if (bad) n_bad++;
      else n_good++;
      // Keep headroom for the next packet so no overflow occurs
      waited = 0;
      while (fill_level > 7'd40 && waited < 500) begin
        cycle();
        waited++;
      end
      if (waited >= 500) begin
        checks++; errors++;
        $display("FAIL t5_drain_timeout fill=%0d want <=40", fill_level);
      end
    end
    rnd_done = 1'b1;
    cycle();
    out_tready = 1'b1;
    repeat (80) cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t5_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t5_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (pkt_cnt !== 16'(n_good) || drop_cnt !== 16'(n_bad) || ovf_cnt !== 16'd0) begin
      errors++;
      $display("FAIL t5_counts pkt=%0d drop=%0d ovf=%0d want %0d %0d 0",
               pkt_cnt, drop_cnt, ovf_cnt, n_good, n_bad);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_tready = 1'b0;
    send_pkt(2, 16'h5000, 1'b0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = 16'h6000 + 16'(i);
      in_tlast  = (i == 5);
      in_tuser  = 1'b0;
      rst       = (i == 2);
      cycle();
      if (i == 2) begin
        checks++;
        if (out_tvalid !== 1'b0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0 ||
            ovf_cnt !== 16'd0 || fill_level !== 7'd0) begin
          errors++;
          $display("FAIL t6_after_rst valid=%b pkt=%0d drop=%0d ovf=%0d fill=%0d want 0",
                   out_tvalid, pkt_cnt, drop_cnt, ovf_cnt, fill_level);
        end
      end
    end
    rst       = 1'b0;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    got_q.delete();
    exp_q.delete();
    add_exp(3, 16'h6003);
    out_tready = 1'b1;
    repeat (6) cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t6_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t6_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++; $display("FAIL t6_pkt_cnt got %0d want 1", pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_drop();
    test_back_to_back_ovf();
    test_long_pkt();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
